// File: rtl/cp0_regfile_irq_pkg.sv
// Shared CP0 constants: register addresses {sel, rd}, exception codes and the Status field layout.
package cp0_regfile_irq_pkg;

  localparam logic [7:0] CR_BADVADDR = 8'h08;
  localparam logic [7:0] CR_COUNT    = 8'h09;
  localparam logic [7:0] CR_COMPARE  = 8'h0b;
  localparam logic [7:0] CR_STATUS   = 8'h0c;
  localparam logic [7:0] CR_CAUSE    = 8'h0d;
  localparam logic [7:0] CR_EPC      = 8'h0e;

  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // Address-error exceptions are the only ones that latch BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_irq_if.sv
// WB-stage to CP0 connection: exception/eret/mtc0 controls in, read data and interrupt request out.
interface cp0_regfile_irq_if;
  logic        wb_valid;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        op_mtc0;
  logic        op_eret;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic [31:0] c0_rdata;
  logic [31:0] c0_epc_out;
  logic        c0_exl_out;
  logic        int_req;

  modport master (
    output wb_valid, wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr,
    output op_mtc0, op_eret, c0_addr, c0_wdata,
    input  c0_rdata, c0_epc_out, c0_exl_out, int_req
  );

  modport slave (
    input  wb_valid, wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr,
    input  op_mtc0, op_eret, c0_addr, c0_wdata,
    output c0_rdata, c0_epc_out, c0_exl_out, int_req
  );
endinterface

// File: rtl/cp0_regfile_irq_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the timer interrupt flag TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div;
  logic          inc;

  // A Count load restarts the prescaler and swallows that cycle's tick.
  assign inc = (div == DIV_LAST) && !count_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + DW'(1);
      end

      if (compare_we) begin
        compare <= wdata;
      end

      // Writing Compare acknowledges the timer interrupt, even against a new match.
      if (compare_we) begin
        ti <= 1'b0;
      end else if (inc && (count == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile_irq.sv
// MIPS CP0 register file beside WB: exception capture, eret, mtc0/mfc0 and interrupt request.
module cp0_regfile_irq
  import cp0_regfile_irq_pkg::*;
#(
  parameter int NUM_HW_INT = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] ext_int_in,
  cp0_regfile_irq_if.slave      bus
);

  logic        mtc0_we;
  logic        eret_we;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [5:0]  ext_int;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] badvaddr;
  logic [31:0] epc;
  status_t     status;
  logic        cause_bd;
  logic [4:0]  cause_excode;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [31:0] rdata;

  assign mtc0_we    = bus.wb_valid & bus.op_mtc0 & ~bus.wb_ex;
  assign eret_we    = bus.wb_valid & bus.op_eret & ~bus.wb_ex;
  assign wr_count   = mtc0_we && (bus.c0_addr == CR_COUNT);
  assign wr_compare = mtc0_we && (bus.c0_addr == CR_COMPARE);
  assign wr_status  = mtc0_we && (bus.c0_addr == CR_STATUS);
  assign wr_cause   = mtc0_we && (bus.c0_addr == CR_CAUSE);
  assign wr_epc     = mtc0_we && (bus.c0_addr == CR_EPC);

  // Missing interrupt lines read as 0 in IP.
  assign ext_int = 6'(ext_int_in);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.c0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr     <= '0;
      epc          <= '0;
      status       <= '0;
      cause_bd     <= 1'b0;
      cause_excode <= '0;
      ip_sw        <= '0;
      ip_hw        <= '0;
    end else begin
      ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
      if (wr_cause) begin
        ip_sw <= bus.c0_wdata[9:8];
      end
      if (wr_status) begin
        status.im <= bus.c0_wdata[15:8];
        status.ie <= bus.c0_wdata[0];
      end

      if (bus.wb_ex) begin
        status.exl   <= 1'b1;
        cause_excode <= bus.wb_excode;
        // A nested exception keeps the original return point.
        if (!status.exl) begin
          cause_bd <= bus.wb_bd;
          epc      <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
        end
        if (is_addr_exc(bus.wb_excode)) begin
          badvaddr <= bus.wb_badvaddr;
        end
      end else begin
        if (eret_we) begin
          status.exl <= 1'b0;
        end else if (wr_status) begin
          status.exl <= bus.c0_wdata[1];
        end
        if (wr_epc) begin
          epc <= bus.c0_wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.c0_addr)
      CR_BADVADDR: rdata = badvaddr;
      CR_COUNT:    rdata = count;
      CR_COMPARE:  rdata = compare;
      CR_STATUS:   rdata = {9'b0, 1'b1, 6'b0, status.im, 6'b0, status.exl, status.ie};
      CR_CAUSE:    rdata = {cause_bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, cause_excode, 2'b0};
      CR_EPC:      rdata = epc;
      default:     rdata = '0;
    endcase
  end

  assign bus.c0_rdata   = rdata;
  assign bus.c0_epc_out = epc;
  assign bus.c0_exl_out = status.exl;
  assign bus.int_req    = status.ie & ~status.exl & (|({ip_hw, ip_sw} & status.im));

endmodule

// File: tb/tb_cp0_regfile_irq.sv
// Scoreboard bench for cp0_regfile_irq: directed scenarios then random traffic against a register-level model.
module tb_cp0_regfile_irq;

  localparam int COUNT_DIV = 2;
  localparam logic [7:0] A_BADV = 8'h08, A_COUNT = 8'h09, A_COMPARE = 8'h0b;
  localparam logic [7:0] A_STATUS = 8'h0c, A_CAUSE = 8'h0d, A_EPC = 8'h0e;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] epc;
    logic        exl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] ext_int_in = '0;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;

  cp0_regfile_irq_if bus();

  cp0_regfile_irq #(.NUM_HW_INT(6), .COUNT_DIV(COUNT_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_int_in (ext_int_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // stimulus for the current cycle
  logic        s_valid, s_ex, s_bd, s_mt, s_er;
  logic [4:0]  s_exc;
  logic [31:0] s_pc, s_badv, s_wd;
  logic [7:0]  s_addr;
  logic [5:0]  s_ext = '0;

  // architectural model state
  logic [31:0] m_badv, m_epc, m_count, m_compare;
  logic [7:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  int          m_phase;

  function void set_idle();
    s_valid = 0; s_ex = 0; s_bd = 0; s_mt = 0; s_er = 0;
    s_exc = '0; s_pc = '0; s_badv = '0; s_wd = '0; s_addr = '0;
  endfunction

  function void apply();
    bus.wb_valid = s_valid; bus.wb_ex = s_ex; bus.wb_excode = s_exc; bus.wb_bd = s_bd;
    bus.wb_pc = s_pc; bus.wb_badvaddr = s_badv; bus.op_mtc0 = s_mt; bus.op_eret = s_er;
    bus.c0_addr = s_addr; bus.c0_wdata = s_wd; ext_int_in = s_ext;
  endfunction

  function void model_reset();
    m_badv = '0; m_epc = '0; m_count = '0; m_compare = '0; m_im = '0; m_ip = '0;
    m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = '0; m_phase = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BADV:    return m_badv;
      A_COUNT:   return m_count;
      A_COMPARE: return m_compare;
      A_STATUS:  return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      A_CAUSE:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_exc) << 2);
      A_EPC:     return m_epc;
      default:   return 32'h0;
    endcase
  endfunction

  // Advance the model across one clock edge with the current stimulus.
  function void model_step();
    logic        mt, er, ti_n;
    logic [31:0] cnt_n;
    logic [7:0]  ip_n;
    mt = s_valid && s_mt && !s_ex;
    er = s_valid && s_er && !s_ex;
    ti_n = m_ti;
    cnt_n = m_count;
    if (mt && s_addr == A_COUNT) begin
      cnt_n = s_wd;
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % COUNT_DIV;
      if (m_phase == 0) begin
        cnt_n = m_count + 1;
        if (m_count == m_compare) ti_n = 1;
      end
    end
    if (mt && s_addr == A_COMPARE) begin
      m_compare = s_wd;
      ti_n = 0;
    end
    ip_n = {s_ext[5] | m_ti, s_ext[4:0], m_ip[1:0]};
    if (mt && s_addr == A_CAUSE) ip_n[1:0] = s_wd[9:8];
    m_ti = ti_n; m_count = cnt_n; m_ip = ip_n;
    if (mt && s_addr == A_STATUS) begin
      m_im = s_wd[15:8];
      m_ie = s_wd[0];
    end
    if (s_ex) begin
      if (!m_exl) begin
        m_bd = s_bd;
        m_epc = s_bd ? s_pc - 32'd4 : s_pc;
      end
      m_exc = s_exc;
      m_exl = 1;
      if (s_exc == 5'd4 || s_exc == 5'd5) m_badv = s_badv;
    end else begin
      if (mt && s_addr == A_STATUS) m_exl = s_wd[1];
      if (mt && s_addr == A_EPC) m_epc = s_wd;
      if (er) m_exl = 0;
    end
  endfunction

  task automatic cyc(input string nm, input bit r, input bit use_c, input logic [31:0] cval);
    exp_t e;
    @(posedge clk); #1;
    rst = r;
    apply();
    if (r) model_reset();
    e.nm = nm;
    e.rdata = use_c ? cval : m_read(s_addr);
    e.irq = m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
    e.epc = m_epc;
    e.exl = m_exl;
    sb.push_back(e);
    if (!r) model_step();
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    set_idle(); s_valid = 1; s_mt = 1; s_addr = a; s_wd = d;
    cyc("mtc0", 0, 0, '0);
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    set_idle(); s_addr = a;
    cyc(nm, 0, 0, '0);
  endtask

  task automatic rdc(input logic [7:0] a, input string nm, input logic [31:0] v);
    set_idle(); s_addr = a;
    cyc(nm, 0, 1, v);
  endtask

  task automatic do_reset();
    set_idle(); s_ext = '0;
    s_addr = A_STATUS; cyc("rst_status", 1, 1, 32'h0040_0000);
    s_addr = A_CAUSE;  cyc("rst_cause", 1, 1, 32'h0);
    s_addr = 8'h00;    cyc("rst_addr0", 0, 1, 32'h0);
  endtask

  task automatic take_ex(input logic [4:0] c, input logic b, input logic [31:0] pc,
                         input logic [31:0] bv, input logic er, input string nm);
    set_idle(); s_valid = 1; s_ex = 1; s_exc = c; s_bd = b; s_pc = pc; s_badv = bv; s_er = er;
    cyc(nm, 0, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.c0_rdata !== e.rdata) begin
          failures++;
          $display("FAIL %s c0_rdata got=%h exp=%h", e.nm, bus.c0_rdata, e.rdata);
        end
        checks++;
        if (bus.int_req !== e.irq) begin
          failures++;
          $display("FAIL %s int_req got=%b exp=%b", e.nm, bus.int_req, e.irq);
        end
        checks++;
        if (bus.c0_epc_out !== e.epc) begin
          failures++;
          $display("FAIL %s c0_epc_out got=%h exp=%h", e.nm, bus.c0_epc_out, e.epc);
        end
        checks++;
        if (bus.c0_exl_out !== e.exl) begin
          failures++;
          $display("FAIL %s c0_exl_out got=%b exp=%b", e.nm, bus.c0_exl_out, e.exl);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] addrs [9] = '{8'h00, 8'h08, 8'h09, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10};
    set_idle();
    model_reset();
    apply();
    do_reset();

    // exception capture, nested exception, eret
    mtc0(A_COMPARE, 32'h8000_0000);
    rd(8'h00, "idle");
    rd(8'h00, "idle");
    take_ex(5'd4, 1'b1, 32'hBFC0_0104, 32'h0000_1003, 1'b0, "ex_adel");
    rdc(A_EPC, "ex1_epc", 32'hBFC0_0100);
    rdc(A_CAUSE, "ex1_cause", 32'h8000_0010);
    rdc(A_BADV, "ex1_badv", 32'h0000_1003);
    rdc(A_STATUS, "ex1_status", 32'h0040_0002);
    take_ex(5'd5, 1'b0, 32'h0000_1234, 32'h0000_2222, 1'b0, "ex_nested");
    rdc(A_EPC, "ex2_epc_hold", 32'hBFC0_0100);
    rdc(A_CAUSE, "ex2_cause", 32'h8000_0014);
    rdc(A_BADV, "ex2_badv", 32'h0000_2222);
    set_idle(); s_valid = 1; s_er = 1; cyc("eret", 0, 0, '0);
    rdc(A_STATUS, "eret_status", 32'h0040_0000);

    // timer interrupt
    mtc0(A_COUNT, 32'd5);
    mtc0(A_COMPARE, 32'd9);
    mtc0(A_STATUS, 32'h0000_8001);
    for (int i = 0; i < 14; i++) rd(A_CAUSE, "timer_wait");
    rdc(A_CAUSE, "timer_ti", 32'hC000_8014);
    mtc0(A_COMPARE, 32'h8000_0000);
    rdc(A_CAUSE, "ti_clear", 32'h8000_8014);
    rdc(A_CAUSE, "ip7_clear", 32'h8000_0014);

    // hardware interrupt line
    s_ext = 6'b000100;
    mtc0(A_STATUS, 32'h0000_1001);
    rdc(A_CAUSE, "hw_ip4", 32'h8000_1014);
    rd(A_STATUS, "hw_irq");
    mtc0(A_STATUS, 32'h0000_1003);
    rd(A_STATUS, "hw_exl_mask");
    mtc0(A_STATUS, 32'h0000_1001);
    rd(A_CAUSE, "hw_irq_again");

    // reset in the middle of activity
    do_reset();

    // simultaneous exception and eret, Count wrap
    mtc0(A_COMPARE, 32'h8000_0000);
    rd(8'h00, "idle");
    take_ex(5'd0, 1'b0, 32'h0000_0400, 32'h0, 1'b1, "ex_eret");
    rdc(A_STATUS, "ex_eret_exl", 32'h0040_0002);
    rdc(A_EPC, "ex_eret_epc", 32'h0000_0400);
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    rdc(A_COUNT, "wrap_hold0", 32'hFFFF_FFFF);
    rdc(A_COUNT, "wrap_hold1", 32'hFFFF_FFFF);
    rdc(A_COUNT, "wrap_zero", 32'h0000_0000);

    // software IP bits and unimplemented address
    mtc0(A_CAUSE, 32'h0000_0300);
    rdc(A_CAUSE, "ip_sw", 32'h0000_0300);
    mtc0(8'h0f, 32'hFFFF_FFFF);
    rdc(8'h0f, "unimpl_rd", 32'h0);
    rdc(A_CAUSE, "unimpl_noeffect", 32'h0000_0300);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      set_idle();
      s_valid = ($urandom_range(0, 9) != 0);
      s_ex = s_valid && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: s_exc = 5'd0;
        1: s_exc = 5'd4;
        2: s_exc = 5'd5;
        default: s_exc = 5'($urandom);
      endcase
      s_bd = 1'($urandom);
      s_pc = $urandom;
      s_badv = $urandom;
      s_mt = ($urandom_range(0, 3) == 0);
      s_er = ($urandom_range(0, 19) == 0);
      s_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 8)];
      s_wd = $urandom;
      if (s_addr == A_COMPARE && $urandom_range(0, 1) == 1) s_wd = m_count + $urandom_range(0, 6);
      if (s_addr == A_COUNT && $urandom_range(0, 1) == 1) s_wd = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      if (s_addr == A_STATUS && $urandom_range(0, 1) == 1) s_wd = (s_wd & ~32'h2) | 32'h1;
      if ($urandom_range(0, 15) == 0) s_ext = 6'($urandom);
      cyc("rand", 0, 0, '0);
    end

    set_idle();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain scoreboard entries left got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
